arb_vrp_pkt: RTL and testbench

ARB_VRP_PKT -- requirements
Module: arb_vrp_pkt

---
 rtl/arb_vrp_pkt.sv | 185 ++++++++++++++++++
 tb/tb_arb_vrp_pkt.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_vrp_pkt.sv
// ---------------------------------------------------------------------------
// arb_vrp_pkt
//   Packet-aware N:1 valid/ready arbiter. It selects one of WIDTH slave
//   channels and forwards its beats {pld, last, id} to a single master port.
//   Arbitration is fixed-priority (MODE=0) or round-robin (MODE=1). With
//   LOCK_EN=1 the grant stays on one channel from its first beat until its
//   last beat. OUT_REG selects a zero-latency pass-through or a 2-entry
//   registered skid stage that isolates rdy_m from v_rdy_s.
//
// Ports
//   clk       : single clock, all state on rising edge
//   rst_n     : synchronous active-low reset
//   v_vld_s   : per-channel valid            (in,  WIDTH)
//   v_rdy_s   : per-channel ready            (out, WIDTH)
//   v_last_s  : per-channel end-of-packet    (in,  WIDTH)
//   v_pld_s   : per-channel payload          (in,  PLD_WIDTH x WIDTH)
//   vld_m     : master valid                 (out)
//   rdy_m     : master ready                 (in)
//   pld_m     : master payload               (out, PLD_WIDTH)
//   last_m    : master end-of-packet         (out)
//   id_m      : source channel of the beat   (out, IDW)
// ---------------------------------------------------------------------------
module arb_vrp_pkt #(
   parameter int  MODE      = 1,
   parameter int  OUT_REG   = 1,
   parameter int  LOCK_EN   = 1,
   parameter int  WIDTH     = 4,
   parameter int  PLD_WIDTH = 32,
   localparam int IDW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     v_vld_s,
   output logic [WIDTH-1:0]     v_rdy_s,
   input  logic [WIDTH-1:0]     v_last_s,
   input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH],
   output logic                 vld_m,
   input  logic                 rdy_m,
   output logic [PLD_WIDTH-1:0] pld_m,
   output logic                 last_m,
   output logic [IDW-1:0]       id_m
);

   // Arbitration state
   logic [IDW-1:0]   r_ptr;       // round-robin search start
   logic             r_locked;    // a packet is in flight
   logic [IDW-1:0]   r_lock_id;   // owner of the in-flight packet

   logic             w_gnt_any;
   logic [IDW-1:0]   w_gnt_id;
   logic [WIDTH-1:0] w_gnt;
   logic             w_in_rdy;    // output side can take a beat this cycle
   logic             w_acc;       // a slave beat is accepted this cycle
   logic             w_acc_last;
   logic [IDW-1:0]   w_ptr_nxt;

   // -----------------------------------------------------------------------
   // Grant selection. While locked the owner keeps the grant even without
   // valid (a bubble), so no other channel can slip into the packet.
   // Both searches run from the far end downward so the last hit, i.e. the
   // highest-priority candidate, wins.
   // -----------------------------------------------------------------------
   always_comb begin : p_arbitrate
      int             w_idx;
      logic [IDW-1:0] w_sel;
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it holding its old value (that would infer a latch).
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      w_idx     = 0;
      w_sel     = '0;
      if (r_locked) begin
         w_gnt_any = 1'b1;
         w_gnt_id  = r_lock_id;
      end else if (MODE == 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            w_sel = IDW'(i);
            if (v_vld_s[w_sel]) begin
               w_gnt_any = 1'b1;
               w_gnt_id  = w_sel;
            end
         end
      end else begin
         for (int k = WIDTH - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % WIDTH;
            w_sel = IDW'(w_idx);
            if (v_vld_s[w_sel]) begin
               w_gnt_any = 1'b1;
               w_gnt_id  = w_sel;
            end
         end
      end
   end

   assign w_gnt      = w_gnt_any ? (WIDTH'(1) << w_gnt_id) : '0;
   assign v_rdy_s    = rst_n ? (w_gnt & {WIDTH{w_in_rdy}}) : '0;
   assign w_acc      = |(v_vld_s & v_rdy_s);
   assign w_acc_last = v_last_s[w_gnt_id];
   assign w_ptr_nxt  = (w_gnt_id == IDW'(WIDTH - 1)) ? '0 : w_gnt_id + IDW'(1);

   // -----------------------------------------------------------------------
   // Lock and pointer. A beat that ends arbitration (last, or any beat when
   // locking is off) releases the lock and moves the pointer past the
   // winner; a non-last beat with locking on claims the lock.
   // -----------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_locked  <= 1'b0;
         r_lock_id <= '0;
      end else if (w_acc) begin
         if ((LOCK_EN != 0) && !w_acc_last) begin
            r_locked  <= 1'b1;
            r_lock_id <= w_gnt_id;
         end else begin
            r_locked  <= 1'b0;
            r_ptr     <= w_ptr_nxt;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Output stage
   // -----------------------------------------------------------------------
   if (OUT_REG == 0) begin : g_pass
      assign w_in_rdy = rdy_m;
      assign vld_m    = |(v_vld_s & w_gnt);
      assign pld_m    = w_gnt_any ? v_pld_s[w_gnt_id]  : '0;
      assign last_m   = w_gnt_any ? v_last_s[w_gnt_id] : 1'b0;
      assign id_m     = w_gnt_any ? w_gnt_id           : '0;
   end else begin : g_skid
      logic [PLD_WIDTH-1:0] r_pld [2];
      logic [1:0]           r_last;
      logic [IDW-1:0]       r_id [2];
      logic                 r_wr_sel;
      logic                 r_rd_sel;
      logic [1:0]           r_cnt;
      logic                 w_push;
      logic                 w_pop;

      // Accept depends only on the local count, never on rdy_m, so the
      // slave-side ready is fully registered. Pushing while full cannot
      // happen because in_rdy is low then.
      assign w_in_rdy = (r_cnt != 2'd2);
      assign w_push   = w_acc;
      assign w_pop    = vld_m & rdy_m;

      // Outputs are masked while empty, which also gives all-zero outputs
      // straight out of reset.
      assign vld_m  = (r_cnt != 2'd0);
      assign pld_m  = vld_m ? r_pld[r_rd_sel]  : '0;
      assign last_m = vld_m ? r_last[r_rd_sel] : 1'b0;
      assign id_m   = vld_m ? r_id[r_rd_sel]   : '0;

      // NOTE: the data entries are deliberately not reset; their contents
      // are only observed through the masked outputs above, and only the
      // pointers and count decide what is valid.
      always_ff @(posedge clk) begin
         if (w_push) begin
            r_pld[r_wr_sel]  <= v_pld_s[w_gnt_id];
            r_last[r_wr_sel] <= w_acc_last;
            r_id[r_wr_sel]   <= w_gnt_id;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_cnt    <= 2'd0;
         end else begin
            if (w_push) r_wr_sel <= ~r_wr_sel;
            if (w_pop)  r_rd_sel <= ~r_rd_sel;
            case ({w_push, w_pop})
               2'b10:   r_cnt <= r_cnt + 2'd1;
               2'b01:   r_cnt <= r_cnt - 2'd1;
               default: r_cnt <= r_cnt;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_arb_vrp_pkt.sv
// ---------------------------------------------------------------------------
// tb_arb_vrp_pkt
//   Two instances share one set of slave inputs:
//     u_rr : MODE=1, OUT_REG=1, LOCK_EN=1 (defaults), checked by a
//            transaction-level model feeding a scoreboard queue.
//     u_fp : MODE=0, OUT_REG=0, LOCK_EN=0, checked combinationally.
//   Directed phases cover the round-robin sequence, packet locking with a
//   bubble, fixed-priority starvation and reset with a full skid stage,
//   followed by a randomized streaming phase.
// ---------------------------------------------------------------------------
module tb_arb_vrp_pkt;

   localparam int W  = 4;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  vld;
   logic [W-1:0]  last;
   logic [PW-1:0] pld [W];
   logic          rdy_m;

   logic [W-1:0]  rdy0, rdy1;
   logic          vld_m0, vld_m1, last_m0, last_m1;
   logic [PW-1:0] pld_m0, pld_m1;
   logic [1:0]    id_m0, id_m1;

   always #5 clk = ~clk;

   arb_vrp_pkt u_rr (
      .clk(clk), .rst_n(rst_n),
      .v_vld_s(vld), .v_rdy_s(rdy0), .v_last_s(last), .v_pld_s(pld),
      .vld_m(vld_m0), .rdy_m(rdy_m), .pld_m(pld_m0), .last_m(last_m0), .id_m(id_m0)
   );

   arb_vrp_pkt #(.MODE(0), .OUT_REG(0), .LOCK_EN(0), .WIDTH(W), .PLD_WIDTH(PW)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .v_vld_s(vld), .v_rdy_s(rdy1), .v_last_s(last), .v_pld_s(pld),
      .vld_m(vld_m1), .rdy_m(rdy_m), .pld_m(pld_m1), .last_m(last_m1), .id_m(id_m1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // -----------------------------------------------------------------------
   // Reference model for u_rr: owner = -1 when no packet is in flight,
   // count = beats held in the output stage, exp_q = beats still to appear.
   // -----------------------------------------------------------------------
   typedef struct {
      logic [PW-1:0] pld;
      logic          last;
      int            id;
   } beat_t;

   beat_t exp_q [$];
   int    m_ptr   = 0;
   int    m_owner = -1;
   int    m_count = 0;
   int    seq [W];
   bit    started = 1'b0;

   // Round-robin choice: the owner if any, else first valid from m_ptr upward.
   function automatic int rr_choice(input logic [W-1:0] v);
      if (m_owner >= 0) return m_owner;
      for (int k = 0; k < W; k++) begin
         if (v[(m_ptr + k) % W]) return (m_ptr + k) % W;
      end
      return -1;
   endfunction

   function automatic int lowest_valid(input logic [W-1:0] v);
      for (int c = 0; c < W; c++) if (v[c]) return c;
      return -1;
   endfunction

   // Advance the model across one rising edge, using the inputs as they
   // stood at that edge.
   task automatic model_update();
      int    g;
      bit    acc;
      bit    pop;
      beat_t b;
      if (!rst_n) begin
         m_ptr   = 0;
         m_owner = -1;
         m_count = 0;
         exp_q.delete();
      end else begin
         pop = (m_count > 0) && rdy_m;
         g   = rr_choice(vld);
         acc = (g >= 0) && vld[g] && (m_count < 2);
         if (acc) begin
            b.pld  = pld[g];
            b.last = last[g];
            b.id   = g;
            exp_q.push_back(b);
            if (!last[g]) m_owner = g;
            else begin
               m_owner = -1;
               m_ptr   = (g + 1) % W;
            end
         end
         // The fixed-priority instance accepts when its own handshake fires;
         // the source of that channel then advances as well.
         for (int c = 0; c < W; c++) begin
            if ((acc && g == c) || (rdy1[c] && vld[c])) seq[c]++;
         end
         m_count = m_count + int'(acc) - int'(pop);
      end
   endtask

   // -----------------------------------------------------------------------
   // Monitor: on the falling edge compare ready vectors and, whenever the
   // master handshake is presented, pop the scoreboard and compare the beat.
   // -----------------------------------------------------------------------
   initial begin
      int            g;
      logic [W-1:0]  exp_rdy;
      beat_t         b;
      forever begin
         @(negedge clk);
         if (started) begin
            g       = rr_choice(vld);
            exp_rdy = '0;
            if (rst_n && g >= 0 && m_count < 2) exp_rdy[g] = 1'b1;
            check("rr_rdy_s", rdy0, exp_rdy);
            check("rr_vld_m", vld_m0, (m_count > 0));
            if (vld_m0 && rdy_m) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL rr_unexpected_beat actual=pld %0h id %0d required=no beat at %0t",
                           pld_m0, id_m0, $time);
               end else begin
                  b = exp_q.pop_front();
                  check("rr_pld_m",  pld_m0,  b.pld);
                  check("rr_last_m", last_m0, b.last);
                  check("rr_id_m",   id_m0,   b.id);
               end
            end

            g       = lowest_valid(vld);
            exp_rdy = '0;
            if (rst_n && rdy_m && g >= 0) exp_rdy[g] = 1'b1;
            check("fp_rdy_s",  rdy1,   exp_rdy);
            check("fp_vld_m",  vld_m1, (g >= 0));
            check("fp_pld_m",  pld_m1, (g >= 0) ? pld[g] : '0);
            check("fp_last_m", last_m1, (g >= 0) ? last[g] : 1'b0);
            check("fp_id_m",   id_m1,  (g >= 0) ? g : 0);
         end
      end
   end

   // -----------------------------------------------------------------------
   // Stimulus
   // -----------------------------------------------------------------------
   task automatic drive(input logic r, input logic [W-1:0] v, input logic [W-1:0] l,
                        input logic rm);
      rst_n = r;
      vld   = v;
      last  = l;
      rdy_m = rm;
      for (int c = 0; c < W; c++) pld[c] = {8'(c), 24'(seq[c])};
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      logic [W-1:0] rv, rl;
      for (int c = 0; c < W; c++) seq[c] = 0;

      // Reset
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      started = 1'b1;

      // Round robin, all valid, all last: grants 0,1,2,3,0, id one cycle later
      drive(1'b1, 4'b1111, 4'b1111, 1'b1);
      check("rr_first_grant", rdy0, 4'b0001);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_seq_id", id_m0, k % 4);
      end

      // Locked packet on ch2 with a bubble; ch0 waits until ch2's last
      drive(1'b1, 4'b0100, 4'b0000, 1'b1);
      check("lock_first", rdy0, 4'b0100);
      tick();
      drive(1'b1, 4'b0001, 4'b0000, 1'b1);
      check("lock_bubble", rdy0, 4'b0100);
      tick();
      drive(1'b1, 4'b0101, 4'b0000, 1'b1);
      check("lock_mid", rdy0, 4'b0100);
      tick();
      drive(1'b1, 4'b0101, 4'b0100, 1'b1);
      check("lock_last", rdy0, 4'b0100);
      tick();
      drive(1'b1, 4'b0001, 4'b0001, 1'b1);
      check("lock_release_ch0", rdy0, 4'b0001);
      tick();

      // Fixed priority: ch1 always beats ch3
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 4'b1010, 4'b1010, 1'b1);
         check("fp_starve", rdy1, 4'b0010);
         tick();
      end

      // Randomized streaming with random master back-pressure
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < W; c++) begin
            rv[c] = ($urandom_range(9, 0) < 7);
            rl[c] = ($urandom_range(2, 0) == 0);
         end
         drive(1'b1, rv, rl, 1'($urandom_range(1, 0)));
         tick();
      end

      // Close any open packet, then drain
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 4'b1111, 4'b1111, 1'b1);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 4'b0000, 4'b0000, 1'b1);
         tick();
      end
      check("drain_empty", vld_m0, 1'b0);

      // Fill the skid stage mid-packet on ch1, then reset for one cycle
      drive(1'b1, 4'b0010, 4'b0000, 1'b0);
      tick();
      tick();
      check("full_vld", vld_m0, 1'b1);
      check("full_rdy", rdy0, 4'b0000);
      drive(1'b0, 4'b1111, 4'b1111, 1'b1);
      check("rdy_in_reset", rdy0, 4'b0000);
      tick();
      check("rst_vld_m",  vld_m0,  1'b0);
      check("rst_pld_m",  pld_m0,  '0);
      check("rst_last_m", last_m0, 1'b0);
      check("rst_id_m",   id_m0,   2'd0);
      drive(1'b1, 4'b1111, 4'b1111, 1'b1);
      check("rst_ch0_first", rdy0, 4'b0001);
      tick();
      check("rst_ch0_out", id_m0, 2'd0);
      for (int k = 0; k < 4; k++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
